// File: rtl/io_mem_burst_arbiter.sv
// Round-robin arbiter sharing one io_mem read/write port among NUM_CLIENTS engines.
// Read and write paths arbitrate independently; a grant is held for the whole burst.
module io_mem_burst_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS*AWIDTH-1:0] c_rd_addr,
  input  logic [NUM_CLIENTS-1:0]        c_rd_addr_valid,
  output logic [NUM_CLIENTS-1:0]        c_rd_addr_ready,
  input  logic [NUM_CLIENTS*32-1:0]     c_rd_len,
  output logic [DWIDTH-1:0]             c_rdata,
  output logic [NUM_CLIENTS-1:0]        c_rdata_valid,
  input  logic [NUM_CLIENTS-1:0]        c_rdata_ready,
  input  logic [NUM_CLIENTS*AWIDTH-1:0] c_wr_addr,
  input  logic [NUM_CLIENTS-1:0]        c_wr_addr_valid,
  output logic [NUM_CLIENTS-1:0]        c_wr_addr_ready,
  input  logic [NUM_CLIENTS*32-1:0]     c_wr_len,
  input  logic [NUM_CLIENTS*DWIDTH-1:0] c_wdata,
  input  logic [NUM_CLIENTS-1:0]        c_wdata_valid,
  output logic [NUM_CLIENTS-1:0]        c_wdata_ready,
  output logic                          c_wr_status,
  output logic [NUM_CLIENTS-1:0]        c_wr_status_valid,
  input  logic [NUM_CLIENTS-1:0]        c_wr_status_ready,
  output logic [AWIDTH-1:0]             req_read_addr,
  output logic                          req_read_addr_valid,
  input  logic                          req_read_addr_ready,
  output logic [31:0]                   req_read_len,
  input  logic [DWIDTH-1:0]             rdata,
  input  logic                          rdata_valid,
  output logic                          rdata_ready,
  output logic [AWIDTH-1:0]             req_write_addr,
  output logic                          req_write_addr_valid,
  input  logic                          req_write_addr_ready,
  output logic [31:0]                   req_write_len,
  output logic [DWIDTH-1:0]             req_write_data,
  output logic                          req_write_data_valid,
  input  logic                          req_write_data_ready,
  input  logic                          resp_write_status,
  input  logic                          resp_write_status_valid,
  output logic                          resp_write_status_ready
);

  // state   | meaning
  // RD_IDLE | no read burst; pick next requester from rd_ptr
  // RD_ADDR | granted client's read address forwarded to io_mem
  // RD_DATA | read beats routed to granted client until rd_cnt hits 0
  // WR_IDLE | no write burst; pick next requester from wr_ptr
  // WR_ADDR | granted client's write address forwarded to io_mem
  // WR_DATA | write beats from granted client forwarded, counted down
  // WR_RESP | io_mem write response routed back to granted client
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_e;

  rd_state_e rd_state_q, rd_state_d;
  wr_state_e wr_state_q, wr_state_d;
  logic [2:0]  rd_g_q, rd_g_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]  wr_g_q, wr_g_d, wr_ptr_q, wr_ptr_d;
  logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  logic [NUM_CLIENTS-1:0] rd_sel, wr_sel;
  logic [AWIDTH-1:0]      rd_sel_addr, wr_sel_addr;
  logic [31:0]            rd_sel_len, wr_sel_len;
  logic [DWIDTH-1:0]      wr_sel_wdata;
  logic                   rd_sel_valid, wr_sel_avalid, wr_sel_wvalid;

  // First requester at or after ptr, wrapping around the client list.
  function automatic logic [2:0] rr_pick(input logic [NUM_CLIENTS-1:0] req, input logic [2:0] ptr);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!found && req[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [2:0] ptr_inc(input logic [2:0] g);
    return (g == 3'(NUM_CLIENTS - 1)) ? 3'd0 : g + 3'd1;
  endfunction

  always_comb begin
    rd_sel       = '0;
    wr_sel       = '0;
    rd_sel_addr  = '0;
    rd_sel_len   = '0;
    wr_sel_addr  = '0;
    wr_sel_len   = '0;
    wr_sel_wdata = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (rd_g_q == 3'(k)) begin
        rd_sel[k]   = 1'b1;
        rd_sel_addr = c_rd_addr[k*AWIDTH +: AWIDTH];
        rd_sel_len  = c_rd_len[k*32 +: 32];
      end
      if (wr_g_q == 3'(k)) begin
        wr_sel[k]    = 1'b1;
        wr_sel_addr  = c_wr_addr[k*AWIDTH +: AWIDTH];
        wr_sel_len   = c_wr_len[k*32 +: 32];
        wr_sel_wdata = c_wdata[k*DWIDTH +: DWIDTH];
      end
    end
    rd_sel_valid  = |(c_rd_addr_valid & rd_sel);
    wr_sel_avalid = |(c_wr_addr_valid & wr_sel);
    wr_sel_wvalid = |(c_wdata_valid & wr_sel);
  end

  always_comb begin
    rd_state_d          = rd_state_q;
    rd_g_d              = rd_g_q;
    rd_ptr_d            = rd_ptr_q;
    rd_cnt_d            = rd_cnt_q;
    req_read_addr       = '0;
    req_read_len        = '0;
    req_read_addr_valid = 1'b0;
    c_rd_addr_ready     = '0;
    c_rdata             = '0;
    c_rdata_valid       = '0;
    rdata_ready         = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (|c_rd_addr_valid) begin
          rd_g_d     = rr_pick(c_rd_addr_valid, rd_ptr_q);
          rd_state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        req_read_addr       = rd_sel_addr;
        req_read_len        = rd_sel_len;
        req_read_addr_valid = rd_sel_valid;
        c_rd_addr_ready     = rd_sel & {NUM_CLIENTS{req_read_addr_ready}};
        if (rd_sel_valid && req_read_addr_ready) begin
          rd_cnt_d   = rd_sel_len;
          rd_ptr_d   = ptr_inc(rd_g_q);
          rd_state_d = (rd_sel_len == 32'd0) ? RD_IDLE : RD_DATA;
        end
      end
      RD_DATA: begin
        c_rdata       = rdata;
        c_rdata_valid = rd_sel & {NUM_CLIENTS{rdata_valid}};
        rdata_ready   = |(c_rdata_ready & rd_sel);
        if (rdata_valid && rdata_ready) begin
          rd_cnt_d = rd_cnt_q - 32'd1;
          if (rd_cnt_q == 32'd1) rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d              = wr_state_q;
    wr_g_d                  = wr_g_q;
    wr_ptr_d                = wr_ptr_q;
    wr_cnt_d                = wr_cnt_q;
    req_write_addr          = '0;
    req_write_len           = '0;
    req_write_addr_valid    = 1'b0;
    c_wr_addr_ready         = '0;
    req_write_data          = '0;
    req_write_data_valid    = 1'b0;
    c_wdata_ready           = '0;
    c_wr_status             = 1'b0;
    c_wr_status_valid       = '0;
    resp_write_status_ready = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (|c_wr_addr_valid) begin
          wr_g_d     = rr_pick(c_wr_addr_valid, wr_ptr_q);
          wr_state_d = WR_ADDR;
        end
      end
      WR_ADDR: begin
        req_write_addr       = wr_sel_addr;
        req_write_len        = wr_sel_len;
        req_write_addr_valid = wr_sel_avalid;
        c_wr_addr_ready      = wr_sel & {NUM_CLIENTS{req_write_addr_ready}};
        if (wr_sel_avalid && req_write_addr_ready) begin
          wr_cnt_d   = wr_sel_len;
          wr_ptr_d   = ptr_inc(wr_g_q);
          wr_state_d = (wr_sel_len == 32'd0) ? WR_RESP : WR_DATA;
        end
      end
      WR_DATA: begin
        req_write_data       = wr_sel_wdata;
        req_write_data_valid = wr_sel_wvalid;
        c_wdata_ready        = wr_sel & {NUM_CLIENTS{req_write_data_ready}};
        if (wr_sel_wvalid && req_write_data_ready) begin
          wr_cnt_d = wr_cnt_q - 32'd1;
          if (wr_cnt_q == 32'd1) wr_state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        c_wr_status             = resp_write_status;
        c_wr_status_valid       = wr_sel & {NUM_CLIENTS{resp_write_status_valid}};
        resp_write_status_ready = |(c_wr_status_ready & wr_sel);
        if (resp_write_status_valid && resp_write_status_ready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Reset abandons any burst in flight; nothing is drained.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= RD_IDLE;
      rd_g_q     <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      wr_state_q <= WR_IDLE;
      wr_g_q     <= '0;
      wr_ptr_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_g_q     <= rd_g_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_state_q <= wr_state_d;
      wr_g_q     <= wr_g_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

endmodule
